// File: rtl/alu_seq_unit.sv
// alu_seq_unit: sequential, handshaked ALU execution unit.
//
// Accepts one request (a, b, oper, flags) on a valid/ready channel, computes it and presents
// the result and flags on a valid/ready response channel. Add/Sub/Rlc/Rrc/reserved finish in
// one cycle. Rol/Ror step one bit position per cycle, so they take 1 + (b mod WORD_WIDTH) cycles.
//
// Optional build macro: ALU_SEQ_FAST_ROT_EN
//   defined   - Rol/Ror use a single-cycle barrel rotator; every op has latency 1.
//   undefined - iterative rotate, one bit per cycle.
//
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous active-high reset
//   req_valid  request present
//   req_ready  unit can accept a request (IDLE only)
//   req_a      operand a
//   req_b      operand b (rotate count for rol/ror, shifted value for rlc/rrc)
//   req_oper   0=Add 1=Sub 2=Rol 3=Ror 4=Rlc 5=Rrc 6,7=reserved (pass a through)
//   req_flags  flags in {N,V,Z,C}, bit0=C
//   rsp_valid  result available (DONE)
//   rsp_ready  consumer takes result
//   rsp_out    result
//   rsp_flags  flags out, same bit order as req_flags
//   busy       high whenever the unit is not IDLE

module alu_seq_unit #(
  parameter int unsigned WORD_WIDTH = 32,
  parameter int unsigned CNT_WIDTH  = $clog2(WORD_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [WORD_WIDTH-1:0] req_a,
  input  logic [WORD_WIDTH-1:0] req_b,
  input  logic [2:0]            req_oper,
  input  logic [3:0]            req_flags,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [WORD_WIDTH-1:0] rsp_out,
  output logic [3:0]            rsp_flags,
  output logic                  busy
);

  localparam logic [2:0] OpAdd = 3'd0;
  localparam logic [2:0] OpSub = 3'd1;
  localparam logic [2:0] OpRol = 3'd2;
  localparam logic [2:0] OpRor = 3'd3;
  localparam logic [2:0] OpRlc = 3'd4;
  localparam logic [2:0] OpRrc = 3'd5;

  localparam int unsigned FlagC = 0;
  localparam int unsigned FlagV = 2;
  localparam int unsigned Msb   = WORD_WIDTH - 1;

  localparam logic [WORD_WIDTH-1:0] WordW = WORD_WIDTH'(WORD_WIDTH);

  typedef enum logic [1:0] {
    StIdle,
    StRot,
    StDone
  } state_e;

  state_e                state_q, state_d;
  logic [WORD_WIDTH-1:0] res_q, res_d;
  logic [3:0]            flags_q, flags_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  rot_left_q, rot_left_d;

  // Flags packed as {N, V, Z, C}; Z and N always follow the result word.
  function automatic logic [3:0] mk_flags(input logic [WORD_WIDTH-1:0] r, input logic c,
                                          input logic v);
    return {r[WORD_WIDTH-1], v, (r == '0), c};
  endfunction

  // Arithmetic on the request operands, used only on the accept edge.
  logic [WORD_WIDTH:0]   sum_ext;
  logic [WORD_WIDTH-1:0] diff;
  logic                  add_v, sub_v, sub_c;
  logic [CNT_WIDTH-1:0]  rot_amt;

  assign sum_ext = {1'b0, req_a} + {1'b0, req_b};
  assign diff    = req_a - req_b;
  assign add_v   = (req_a[Msb] == req_b[Msb]) && (sum_ext[Msb] != req_a[Msb]);
  assign sub_v   = (req_a[Msb] != req_b[Msb]) && (diff[Msb] != req_a[Msb]);
  assign sub_c   = (req_a >= req_b);
  assign rot_amt = CNT_WIDTH'(req_b % WordW);

`ifdef ALU_SEQ_FAST_ROT_EN
  logic [2*WORD_WIDTH-1:0] rol_dbl, ror_dbl;
  logic [WORD_WIDTH-1:0]   rol_word, ror_word;

  assign rol_dbl  = {req_a, req_a} << rot_amt;
  assign ror_dbl  = {req_a, req_a} >> rot_amt;
  assign rol_word = rol_dbl[2*WORD_WIDTH-1:WORD_WIDTH];
  assign ror_word = ror_dbl[WORD_WIDTH-1:0];
`endif

  // One iterative rotate step on the working register. The carry is the bit that
  // crosses the word boundary on this step.
  logic [WORD_WIDTH-1:0] step_word;
  logic                  step_c;

  always_comb begin
    if (rot_left_q) begin
      step_word = {res_q[WORD_WIDTH-2:0], res_q[Msb]};
      step_c    = res_q[Msb];
    end else begin
      step_word = {res_q[0], res_q[WORD_WIDTH-1:1]};
      step_c    = res_q[0];
    end
  end

  always_comb begin
    state_d    = state_q;
    res_d      = res_q;
    flags_d    = flags_q;
    cnt_d      = cnt_q;
    rot_left_d = rot_left_q;

    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          state_d = StDone;
          case (req_oper)
            OpAdd: begin
              res_d   = sum_ext[WORD_WIDTH-1:0];
              flags_d = mk_flags(sum_ext[WORD_WIDTH-1:0], sum_ext[WORD_WIDTH], add_v);
            end
            OpSub: begin
              res_d   = diff;
              flags_d = mk_flags(diff, sub_c, sub_v);
            end
            OpRol, OpRor: begin
              rot_left_d = (req_oper == OpRol);
`ifdef ALU_SEQ_FAST_ROT_EN
              if (rot_amt == '0) begin
                res_d   = req_a;
                flags_d = mk_flags(req_a, req_flags[FlagC], req_flags[FlagV]);
              end else if (req_oper == OpRol) begin
                res_d   = rol_word;
                flags_d = mk_flags(rol_word, rol_word[0], req_flags[FlagV]);
              end else begin
                res_d   = ror_word;
                flags_d = mk_flags(ror_word, ror_word[Msb], req_flags[FlagV]);
              end
`else
              // Zero count keeps the incoming carry; otherwise each step overwrites it.
              res_d   = req_a;
              flags_d = mk_flags(req_a, req_flags[FlagC], req_flags[FlagV]);
              cnt_d   = rot_amt;
              if (rot_amt != '0) begin
                state_d = StRot;
              end
`endif
            end
            OpRlc: begin
              res_d   = {req_b[WORD_WIDTH-2:0], req_flags[FlagC]};
              flags_d = mk_flags({req_b[WORD_WIDTH-2:0], req_flags[FlagC]}, req_b[Msb],
                                 req_flags[FlagV]);
            end
            OpRrc: begin
              res_d   = {req_flags[FlagC], req_b[WORD_WIDTH-1:1]};
              flags_d = mk_flags({req_flags[FlagC], req_b[WORD_WIDTH-1:1]}, req_b[0],
                                 req_flags[FlagV]);
            end
            default: begin
              res_d   = req_a;
              flags_d = req_flags;
            end
          endcase
        end
      end

      StRot: begin
        res_d   = step_word;
        flags_d = mk_flags(step_word, step_c, flags_q[FlagV]);
        cnt_d   = cnt_q - CNT_WIDTH'(1);
        if (cnt_q == CNT_WIDTH'(1)) begin
          state_d = StDone;
        end
      end

      StDone: begin
        if (rsp_ready) begin
          state_d = StIdle;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      res_q      <= '0;
      flags_q    <= '0;
      cnt_q      <= '0;
      rot_left_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      res_q      <= res_d;
      flags_q    <= flags_d;
      cnt_q      <= cnt_d;
      rot_left_q <= rot_left_d;
    end
  end

  assign req_ready = (state_q == StIdle);
  assign rsp_valid = (state_q == StDone);
  assign busy      = (state_q != StIdle);
  assign rsp_out   = res_q;
  assign rsp_flags = flags_q;

endmodule

// File: tb/tb_alu_seq_unit.sv
module tb_alu_seq_unit;

  localparam int W = 32;

  logic         clk;
  logic         rst;
  logic         req_valid;
  logic         req_ready;
  logic [W-1:0] req_a;
  logic [W-1:0] req_b;
  logic [2:0]   req_oper;
  logic [3:0]   req_flags;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [W-1:0] rsp_out;
  logic [3:0]   rsp_flags;
  logic         busy;

  int checks;
  int failures;

  alu_seq_unit #(.WORD_WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_oper  (req_oper),
    .req_flags (req_flags),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_out   (rsp_out),
    .rsp_flags (rsp_flags),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model from the operation definitions; flags returned as {N,V,Z,C}.
  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic [2:0] op, input logic [3:0] fi,
                                output logic [W-1:0] out, output logic [3:0] fo,
                                output int lat);
    longint ua, ub, s, ss;
    logic   c, v;
    int     n;
    ua  = longint'(a);
    ub  = longint'(b);
    c   = fi[0];
    v   = fi[2];
    lat = 1;
    out = a;
    case (op)
      3'd0: begin
        s   = ua + ub;
        out = s[W-1:0];
        c   = s[W];
        ss  = longint'($signed(a)) + longint'($signed(b));
        v   = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
      end
      3'd1: begin
        s   = ua - ub;
        out = s[W-1:0];
        c   = (ua >= ub);
        ss  = longint'($signed(a)) - longint'($signed(b));
        v   = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
      end
      3'd2, 3'd3: begin
        n = int'(ub % W);
`ifndef ALU_SEQ_FAST_ROT_EN
        lat = 1 + n;
`endif
        if (n != 0) begin
          for (int i = 0; i < W; i++) begin
            if (op == 3'd2) out[(i + n) % W] = a[i];
            else            out[i] = a[(i + n) % W];
          end
          c = (op == 3'd2) ? a[W - n] : a[n - 1];
        end
      end
      3'd4: begin
        out = {b[W-2:0], fi[0]};
        c   = b[W-1];
      end
      3'd5: begin
        out = {fi[0], b[W-1:1]};
        c   = b[0];
      end
      default: ;
    endcase
    if (op inside {3'd6, 3'd7}) fo = fi;
    else                        fo = {out[W-1], v, (out == '0), c};
  endfunction

  // Drives one request and collects the response; never judges it.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] op,
                        input logic [3:0] fi, output logic [W-1:0] out,
                        output logic [3:0] fo, output int lat);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!req_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    req_valid = 1'b1;
    req_a     = a;
    req_b     = b;
    req_oper  = op;
    req_flags = fi;
    @(posedge clk);
    @(negedge clk);
    // Scramble inputs after the accept edge; they must be ignored.
    req_valid = 1'b0;
    req_a     = $urandom;
    req_b     = $urandom;
    req_oper  = 3'($urandom);
    req_flags = 4'($urandom);
    lat = 1;
    while (!rsp_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    out       = rsp_out;
    fo        = rsp_flags;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (req_ready !== 1'b1) begin
        failures++;
        $display("FAIL reset_req_ready got=%b want=1", req_ready);
      end
      checks++;
      if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
        failures++;
        $display("FAIL reset_valid_busy got=%b/%b want=0/0", rsp_valid, busy);
      end
      checks++;
      if (rsp_out !== '0 || rsp_flags !== 4'h0) begin
        failures++;
        $display("FAIL reset_out_flags got=%h/%h want=0/0", rsp_out, rsp_flags);
      end
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic test_directed;
    logic [W-1:0] ta[8], tb[8], tout[8];
    logic [2:0]   top[8];
    logic [3:0]   tfi[8], tfo[8];
    int           tlat[8];
    logic [W-1:0] out;
    logic [3:0]   fo;
    int           lat;
    ta = '{32'h5, 32'h8000_0000, 32'h1234, 32'h8000_0001, 32'h1, 32'h0, 32'h0, 32'hdead_beef};
    tb = '{32'h7, 32'h1, 32'h1234, 32'd33, 32'd32, 32'h8000_0000, 32'h1, 32'h5};
    top = '{3'd1, 3'd1, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6};
    tfi = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h5, 4'h1, 4'h0, 4'ha};
    tout = '{32'hFFFF_FFFE, 32'h7FFF_FFFF, 32'h0, 32'h3, 32'h1, 32'h1, 32'h0, 32'hdead_beef};
    tfo = '{4'b1000, 4'b0101, 4'b0011, 4'b0001, 4'b0101, 4'b0001, 4'b0011, 4'ha};
`ifdef ALU_SEQ_FAST_ROT_EN
    tlat = '{1, 1, 1, 1, 1, 1, 1, 1};
`else
    tlat = '{1, 1, 1, 2, 1, 1, 1, 1};
`endif
    for (int i = 0; i < 8; i++) begin
      run_op(ta[i], tb[i], top[i], tfi[i], out, fo, lat);
      checks++;
      if (out !== tout[i]) begin
        failures++;
        $display("FAIL directed_out[%0d] got=%h want=%h", i, out, tout[i]);
      end
      checks++;
      if (fo !== tfo[i]) begin
        failures++;
        $display("FAIL directed_flags[%0d] got=%b want=%b", i, fo, tfo[i]);
      end
      checks++;
      if (lat != tlat[i]) begin
        failures++;
        $display("FAIL directed_latency[%0d] got=%0d want=%0d", i, lat, tlat[i]);
      end
    end
  endtask

  task automatic test_random;
    logic [W-1:0] a, b, out, eout;
    logic [2:0]   op;
    logic [3:0]   fi, fo, efo;
    int           lat, elat;
    for (int i = 0; i < 40; i++) begin
      a  = $urandom;
      b  = (i % 5 == 0) ? a : $urandom;
      op = 3'($urandom_range(0, 7));
      fi = 4'($urandom);
      model(a, b, op, fi, eout, efo, elat);
      run_op(a, b, op, fi, out, fo, lat);
      checks++;
      if (out !== eout || fo !== efo) begin
        failures++;
        $display("FAIL random[%0d] op=%0d a=%h b=%h got=%h/%b want=%h/%b",
                 i, op, a, b, out, fo, eout, efo);
      end
      checks++;
      if (lat != elat) begin
        failures++;
        $display("FAIL random_latency[%0d] op=%0d got=%0d want=%0d", i, op, lat, elat);
      end
    end
  endtask

  task automatic test_backpressure;
    logic [W-1:0] a, b, eout;
    logic [3:0]   efo;
    int           elat, guard;
    a = $urandom;
    b = $urandom;
    model(a, b, 3'd0, 4'h0, eout, efo, elat);
    @(negedge clk);
    req_valid = 1'b1;
    req_a     = a;
    req_b     = b;
    req_oper  = 3'd0;
    req_flags = 4'h0;
    @(posedge clk);
    @(negedge clk);
    guard = 0;
    while (!rsp_valid && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    // A second request stays pending while the response is held.
    req_a = $urandom;
    req_b = $urandom;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (rsp_valid !== 1'b1 || rsp_out !== eout || rsp_flags !== efo) begin
        failures++;
        $display("FAIL hold[%0d] got=%b/%h/%b want=1/%h/%b", i, rsp_valid, rsp_out, rsp_flags,
                 eout, efo);
      end
      checks++;
      if (req_ready !== 1'b0) begin
        failures++;
        $display("FAIL hold_req_ready[%0d] got=%b want=0", i, req_ready);
      end
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    req_valid = 1'b0;
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL retire got valid/ready/busy=%b/%b/%b want=0/1/0", rsp_valid, req_ready,
               busy);
    end
  endtask

  task automatic test_abort;
    logic [W-1:0] a, b, out, eout;
    logic [3:0]   fo, efo;
    int           lat, elat;
    @(negedge clk);
    req_valid = 1'b1;
    req_a     = $urandom;
    req_b     = 32'd31;
    req_oper  = 3'd2;
    req_flags = 4'h0;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    for (int i = 0; i < 9; i++) begin
      checks++;
      if (busy !== 1'b1) begin
        failures++;
        $display("FAIL abort_busy[%0d] got=%b want=1", i, busy);
      end
`ifndef ALU_SEQ_FAST_ROT_EN
      checks++;
      if (rsp_valid !== 1'b0) begin
        failures++;
        $display("FAIL abort_early_valid[%0d] got=%b want=0", i, rsp_valid);
      end
`endif
      @(negedge clk);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || busy !== 1'b0 || rsp_out !== '0 ||
        rsp_flags !== 4'h0) begin
      failures++;
      $display("FAIL abort_reset got ready/valid/busy/out/flags=%b/%b/%b/%h/%b want=1/0/0/0/0",
               req_ready, rsp_valid, busy, rsp_out, rsp_flags);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL abort_after got valid/busy=%b/%b want=0/0", rsp_valid, busy);
    end
    a = $urandom;
    b = $urandom;
    model(a, b, 3'd3, 4'h4, eout, efo, elat);
    run_op(a, b, 3'd3, 4'h4, out, fo, lat);
    checks++;
    if (out !== eout || fo !== efo || lat != elat) begin
      failures++;
      $display("FAIL abort_next got=%h/%b/%0d want=%h/%b/%0d", out, fo, lat, eout, efo, elat);
    end
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rst       = 1'b1;
    req_valid = 1'b0;
    req_a     = '0;
    req_b     = '0;
    req_oper  = 3'd0;
    req_flags = 4'h0;
    rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    test_reset;
    test_directed;
    test_random;
    test_backpressure;
    test_abort;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
